// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parametrised vending controller: credit, vend pulse, change payout, cancel refund
// Optional inactivity auto-refund enabled with `define VEND_TIMEOUT_EN.
module vend_ctrl_param #(
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 5,
  parameter int COIN1_VAL   = 1,
  parameter int COIN2_VAL   = 2,
  parameter int COIN3_VAL   = 5,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TO_W        = 10
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [1:0]          D_in,
  input  logic                Cancel,
  output logic                D_out,
  output logic                D_C,
  output logic                Coin_rej,
  output logic                Busy,
  output logic [CREDIT_W-1:0] Credit
);

  localparam int MAX_COIN =
    (COIN1_VAL > COIN2_VAL) ? ((COIN1_VAL > COIN3_VAL) ? COIN1_VAL : COIN3_VAL)
                            : ((COIN2_VAL > COIN3_VAL) ? COIN2_VAL : COIN3_VAL);

  // Largest possible sum is a just-short-of-price credit plus the biggest coin.
  if (PRICE + MAX_COIN > (2 ** CREDIT_W) - 1) begin : g_bad_credit_w
    $error("vend_ctrl_param: CREDIT_W too small for PRICE plus largest coin");
  end
  if (PRICE < 1) begin : g_bad_price
    $error("vend_ctrl_param: PRICE must be at least 1");
  end
  if ((2 ** TO_W) <= TIMEOUT_CYC) begin : g_bad_to_w
    $error("vend_ctrl_param: TO_W too small for TIMEOUT_CYC");
  end

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] COIN1_C = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] COIN2_C = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] COIN3_C = CREDIT_W'(COIN3_VAL);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                d_out_q, d_out_d;
  logic                d_c_q, d_c_d;
  logic                coin_rej_q, coin_rej_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                coin_vld;

`ifdef VEND_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
`endif

  always_comb begin
    coin_val = '0;
    case (D_in)
      2'b01:   coin_val = COIN1_C;
      2'b10:   coin_val = COIN2_C;
      2'b11:   coin_val = COIN3_C;
      default: coin_val = '0;
    endcase
    coin_vld = (D_in != 2'b00);
    sum      = credit_q + coin_val;
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    coin_rej_d = 1'b0;
`ifdef VEND_TIMEOUT_EN
    to_d       = '0;
`endif

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (coin_vld) begin
          // A cancel alongside a coin in COLLECT refunds the whole sum, even past price.
          if (state_q == S_COLLECT && Cancel) begin
            state_d  = S_CHANGE;
            credit_d = sum;
          end else if (sum >= PRICE_C) begin
            state_d  = S_VEND;
            credit_d = sum - PRICE_C;
          end else begin
            state_d  = S_COLLECT;
            credit_d = sum;
          end
        end else if (state_q == S_COLLECT) begin
          if (Cancel) begin
            state_d = S_CHANGE;
          end else begin
`ifdef VEND_TIMEOUT_EN
            if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
              state_d = S_CHANGE;
            end else begin
              to_d = to_q + TO_W'(1);
            end
`endif
          end
        end
      end
      S_VEND: begin
        coin_rej_d = coin_vld;
        state_d    = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        coin_rej_d = coin_vld;
        credit_d   = credit_q - ONE_C;
        state_d    = (credit_q == ONE_C) ? S_IDLE : S_CHANGE;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase

    d_out_d = (state_d == S_VEND);
    d_c_d   = (state_d == S_CHANGE);
    busy_d  = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      d_out_q    <= 1'b0;
      d_c_q      <= 1'b0;
      coin_rej_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      d_out_q    <= d_out_d;
      d_c_q      <= d_c_d;
      coin_rej_q <= coin_rej_d;
      busy_q     <= busy_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  assign D_out    = d_out_q;
  assign D_C      = d_c_q;
  assign Coin_rej = coin_rej_q;
  assign Busy     = busy_q;
  assign Credit   = credit_q;

endmodule
